// File: rtl/bubble_sort_engine.sv
// bubble_sort_engine: multi-cycle in-place bubble sorter with serial output.
// Captures N W-bit words on a start pulse, performs one compare-swap per
// clock, then streams the sorted words out one per clock on data_out.
// Optional build macro: SORT_DESCEND_EN (largest first instead of smallest).
module bubble_sort_engine #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] data_in [N-1:0],
   input  logic         sort_start,
   output logic [W-1:0] data_out
);

   // Index/counter width: must hold 0..N-1
   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
   localparam logic [CW-1:0] LAST_CMP = CW'(N - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SORT   = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  mem [N-1:0];
   logic [CW-1:0] p;
   logic [CW-1:0] j;
   logic [CW-1:0] k;

   logic [CW-1:0] j_nxt_c;
   logic [W-1:0]  word_a_c;
   logic [W-1:0]  word_b_c;
   logic          swap_c;
   logic          pass_end_c;
   logic          sort_end_c;

   // Compare datapath for the current adjacent pair and pass bookkeeping
   always_comb begin
      j_nxt_c    = j + CW'(1);
      word_a_c   = mem[j];
      word_b_c   = mem[j_nxt_c];
`ifdef SORT_DESCEND_EN
      swap_c     = (word_a_c < word_b_c);
`else
      swap_c     = (word_a_c > word_b_c);
`endif
      pass_end_c = (j == (LAST_CMP - p));
      sort_end_c = pass_end_c && (p == LAST_CMP);
   end

   // Control FSM, word storage, counters and registered serial output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         data_out <= '0;
         p        <= '0;
         j        <= '0;
         k        <= '0;
         for (int i = 0; i < int'(N); i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               data_out <= '0;
               p        <= '0;
               j        <= '0;
               k        <= '0;
               if (sort_start) begin
                  for (int i = 0; i < int'(N); i++) begin
                     mem[i] <= data_in[i];
                  end
                  state <= ST_SORT;
               end
            end

            ST_SORT: begin
               data_out <= '0;
               if (swap_c) begin
                  mem[j]       <= word_b_c;
                  mem[j_nxt_c] <= word_a_c;
               end
               if (sort_end_c) begin
                  p     <= '0;
                  j     <= '0;
                  k     <= '0;
                  state <= ST_OUTPUT;
               end else if (pass_end_c) begin
                  p <= p + CW'(1);
                  j <= '0;
               end else begin
                  j <= j_nxt_c;
               end
            end

            // Last word stays on data_out for one cycle; the IDLE edge clears it
            ST_OUTPUT: begin
               data_out <= mem[k];
               if (k == LAST_IDX) begin
                  k     <= '0;
                  state <= ST_IDLE;
               end else begin
                  k <= k + CW'(1);
               end
            end

            default: begin
               data_out <= '0;
               p        <= '0;
               j        <= '0;
               k        <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed testbench for bubble_sort_engine (N=4, W=4).
module tb_bubble_sort_engine;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4;

   logic         clk;
   logic         reset;
   logic [W-1:0] data_in [N-1:0];
   logic         sort_start;
   logic [W-1:0] data_out;

   int total;
   int bad;

   typedef struct {
      logic [3:0][3:0] din;
      logic [3:0][3:0] asc;
      int              mode;   // 0 plain, 1 busy re-start at E3, 2 start held high
      string           tag;
   } vec_t;

   vec_t tbl [8];

   bubble_sort_engine #(.N(N), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .sort_start (sort_start),
      .data_out   (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0][3:0] order(input logic [3:0][3:0] asc);
      logic [3:0][3:0] r;
`ifdef SORT_DESCEND_EN
      for (int i = 0; i < 4; i++) r[i] = asc[3-i];
`else
      r = asc;
`endif
      return r;
   endfunction

   task automatic set_din(input logic [3:0][3:0] v);
      for (int i = 0; i < 4; i++) data_in[i] = v[i];
   endtask

   // Start at E0, check zeros on E0..E6 and sorted words on E7..E10
   task automatic run_vec(input logic [3:0][3:0] vin, input logic [3:0][3:0] vasc,
                          input int mode, input string tag);
      logic [3:0][3:0] vexp;
      logic [3:0][3:0] zeros;
      vexp  = order(vasc);
      zeros = '0;
      set_din(vin);
      sort_start = 1'b1;
      step();
      check({tag, "_e0"}, data_out, 4'd0);
      if (mode != 2) sort_start = 1'b0;
      if (mode == 2) set_din(zeros);
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c <= 6) check($sformatf("%s_sort_e%0d", tag, c), data_out, 4'd0);
         else        check($sformatf("%s_word%0d", tag, c - 7), data_out, vexp[c-7]);
         if (mode == 1 && c == 2) begin
            sort_start = 1'b1;
            set_din(zeros);
         end
         if (mode == 1 && c == 3) sort_start = 1'b0;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;

      tbl[0] = '{{4'd6, 4'd11, 4'd8, 4'd5}, {4'd11, 4'd8, 4'd6, 4'd5},  0, "basic"};
      tbl[1] = '{{4'd0, 4'd3, 4'd10, 4'd15}, {4'd15, 4'd10, 4'd3, 4'd0}, 0, "reverse"};
      tbl[2] = '{{4'd4, 4'd3, 4'd2, 4'd1},  {4'd4, 4'd3, 4'd2, 4'd1},   0, "sorted"};
      tbl[3] = '{{4'd7, 4'd2, 4'd7, 4'd7},  {4'd7, 4'd7, 4'd7, 4'd2},   0, "dups"};
      tbl[4] = '{{4'd9, 4'd9, 4'd9, 4'd9},  {4'd9, 4'd9, 4'd9, 4'd9},   0, "equal"};
      tbl[5] = '{{4'd6, 4'd11, 4'd8, 4'd5}, {4'd11, 4'd8, 4'd6, 4'd5},  1, "busy"};
      tbl[6] = '{{4'd0, 4'd2, 4'd1, 4'd3},  {4'd3, 4'd2, 4'd1, 4'd0},   2, "held"};
      tbl[7] = '{{4'd15, 4'd0, 4'd15, 4'd0}, {4'd15, 4'd15, 4'd0, 4'd0}, 0, "mixed"};

      reset      = 1'b0;
      sort_start = 1'b0;
      for (int i = 0; i < int'(N); i++) data_in[i] = '0;
      #2;
      check("reset_out", data_out, 4'd0);
      step(); step(); step();
      reset = 1'b1;
      step();
      check("post_reset_idle", data_out, 4'd0);

      // Back-to-back: each new start lands on E11 of the previous sort
      for (int v = 0; v < 8; v++) begin
         run_vec(tbl[v].din, tbl[v].asc, tbl[v].mode, tbl[v].tag);
      end
      sort_start = 1'b0;
      step();
      check("final_e11", data_out, 4'd0);
      step();
      check("idle_after", data_out, 4'd0);

      // Async reset in the middle of SORT
      set_din({4'd6, 4'd11, 4'd8, 4'd5});
      sort_start = 1'b1;
      step();
      sort_start = 1'b0;
      for (int c = 1; c <= 4; c++) step();
      #2 reset = 1'b0;
      #1 check("rst_mid_sort", data_out, 4'd0);
      step(); step();
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         check($sformatf("rst_sort_quiet%0d", c), data_out, 4'd0);
      end
      run_vec({4'd0, 4'd2, 4'd1, 4'd3}, {4'd3, 4'd2, 4'd1, 4'd0}, 0, "after_rst");
      sort_start = 1'b0;
      step();
      check("after_rst_e11", data_out, 4'd0);

      // Async reset in the middle of OUTPUT must kill the stream at once
      set_din({4'd0, 4'd3, 4'd10, 4'd15});
      sort_start = 1'b1;
      step();
      sort_start = 1'b0;
      for (int c = 1; c <= 8; c++) step();
      begin
         logic [3:0][3:0] e;
         e = order({4'd15, 4'd10, 4'd3, 4'd0});
         check("pre_rst_word1", data_out, e[1]);
      end
      #2 reset = 1'b0;
      #1 check("rst_mid_out", data_out, 4'd0);
      step();
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         check($sformatf("rst_out_quiet%0d", c), data_out, 4'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
